// File: rtl/id_stage_hs_if.sv
// Handshake bundle between IF, the decode stage and EX.
// The master modport is the environment side; the slave modport is the stage.
interface id_stage_hs_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      ir_i;
   logic [XLEN-1:0]  pc_i;
   logic             flush_i;
   logic             out_valid;
   logic             out_ready;
   logic [5:0]       op_o;
   logic [5:0]       func_o;
   logic [4:0]       shamt_o;
   logic [XLEN-1:0]  imm_o;
   logic [4:0]       ra_o;
   logic [4:0]       rb_o;
   logic [4:0]       rw_o;
   logic [1:0]       rw_src_o;
   logic             mem_we_o;
   logic             pcwr_en_o;
   logic [1:0]       br_type_o;
   logic [XLEN-1:0]  target_o;
   logic [XLEN-1:0]  pc_o;
   logic             illegal_o;
   logic [CNT_W-1:0] bubble_cnt_o;

   modport master (
      output in_valid, ir_i, pc_i, flush_i, out_ready,
      input  in_ready, out_valid, op_o, func_o, shamt_o, imm_o, ra_o, rb_o, rw_o, rw_src_o,
             mem_we_o, pcwr_en_o, br_type_o, target_o, pc_o, illegal_o, bubble_cnt_o
   );

   modport slave (
      input  in_valid, ir_i, pc_i, flush_i, out_ready,
      output in_ready, out_valid, op_o, func_o, shamt_o, imm_o, ra_o, rb_o, rw_o, rw_src_o,
             mem_we_o, pcwr_en_o, br_type_o, target_o, pc_o, illegal_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_stage_hs.sv
// MIPS decode stage with valid/ready on both sides, flush, load-use bubble insertion,
// illegal-opcode flagging, branch/jump target computation and a saturating bubble counter.
module id_stage_hs #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned LINK_REG  = 31,
   parameter bit          EN_HAZARD = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   id_stage_hs_if.slave  bus
);
   localparam logic [1:0] SrcNone = 2'b00;
   localparam logic [1:0] SrcAlu  = 2'b01;
   localparam logic [1:0] SrcRam  = 2'b10;
   localparam logic [1:0] SrcPc   = 2'b11;

   typedef struct packed {
      logic [5:0]      op;
      logic [5:0]      func;
      logic [4:0]      shamt;
      logic [XLEN-1:0] imm;
      logic [4:0]      ra;
      logic [4:0]      rb;
      logic [4:0]      rw;
      logic [1:0]      rw_src;
      logic            mem_we;
      logic            pcwr;
      logic [1:0]      br_type;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } bundle_t;

   localparam bundle_t BundleRst = '{op: 6'h3F, default: '0};

   logic             out_valid_q, out_valid_d;
   bundle_t          bundle_q, bundle_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   bundle_t         dec;
   logic            uses_ra, uses_rb;
   logic [4:0]      rs, rt, rd;
   logic [XLEN-1:0] simm, zimm, pc4, br_tgt, j_tgt;
   logic            adv, hazard;

   assign rs     = bus.ir_i[25:21];
   assign rt     = bus.ir_i[20:16];
   assign rd     = bus.ir_i[15:11];
   assign simm   = {{(XLEN-16){bus.ir_i[15]}}, bus.ir_i[15:0]};
   assign zimm   = {{(XLEN-16){1'b0}}, bus.ir_i[15:0]};
   assign pc4    = bus.pc_i + XLEN'(4);
   assign br_tgt = pc4 + (simm << 2);
   assign j_tgt  = {pc4[XLEN-1:28], bus.ir_i[25:0], 2'b00};

   always_comb begin
      dec         = '0;
      dec.op      = bus.ir_i[31:26];
      dec.func    = bus.ir_i[5:0];
      dec.shamt   = bus.ir_i[10:6];
      dec.pc      = bus.pc_i;
      uses_ra     = 1'b0;
      uses_rb     = 1'b0;
      case (bus.ir_i[31:26])
         6'b000000: begin
            dec.ra = rs; dec.rb = rt; dec.rw = rd; dec.rw_src = SrcAlu;
            uses_ra = 1'b1; uses_rb = 1'b1;
         end
         6'b001000: begin
            dec.ra = rs; dec.rw = rt; dec.rw_src = SrcAlu; dec.imm = simm; uses_ra = 1'b1;
         end
         6'b001100, 6'b001101: begin
            dec.ra = rs; dec.rw = rt; dec.rw_src = SrcAlu; dec.imm = zimm; uses_ra = 1'b1;
         end
         6'b001111: begin
            dec.rw = rt; dec.rw_src = SrcAlu; dec.imm = zimm << 16;
         end
         6'b100011: begin
            dec.ra = rs; dec.rw = rt; dec.rw_src = SrcRam; dec.imm = simm; uses_ra = 1'b1;
         end
         6'b101011: begin
            dec.ra = rs; dec.rb = rt; dec.mem_we = 1'b1; dec.imm = simm;
            uses_ra = 1'b1; uses_rb = 1'b1;
         end
         6'b000100, 6'b000101: begin
            dec.ra = rs; dec.rb = rt; dec.pcwr = 1'b1; dec.imm = simm; dec.target = br_tgt;
            dec.br_type = bus.ir_i[26] ? 2'b10 : 2'b01;
            uses_ra = 1'b1; uses_rb = 1'b1;
         end
         6'b000010: begin
            dec.pcwr = 1'b1; dec.br_type = 2'b11; dec.target = j_tgt;
         end
         6'b000011: begin
            dec.pcwr = 1'b1; dec.br_type = 2'b11; dec.target = j_tgt;
            dec.rw = 5'(LINK_REG); dec.rw_src = SrcPc;
         end
         default: dec.illegal = 1'b1;
      endcase
      // Writes to r0 are discarded, so the bundle must not request a write-back.
      if (dec.rw == 5'd0) dec.rw_src = SrcNone;
   end

   assign adv    = !out_valid_q || bus.out_ready;
   assign hazard = EN_HAZARD && out_valid_q && (bundle_q.rw_src == SrcRam) &&
                   (bundle_q.rw != 5'd0) && bus.in_valid &&
                   ((uses_ra && (rs == bundle_q.rw)) || (uses_rb && (rt == bundle_q.rw)));
   assign bus.in_ready = bus.flush_i || (adv && !hazard);

   always_comb begin
      out_valid_d  = out_valid_q;
      bundle_d     = bundle_q;
      bubble_cnt_d = bubble_cnt_q;
      if (bus.flush_i) begin
         out_valid_d = 1'b0;
      end else if (adv) begin
         if (hazard) begin
            out_valid_d = 1'b0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
         end else if (bus.in_valid) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         bundle_q     <= BundleRst;
         bubble_cnt_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         bundle_q     <= bundle_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.op_o         = bundle_q.op;
   assign bus.func_o       = bundle_q.func;
   assign bus.shamt_o      = bundle_q.shamt;
   assign bus.imm_o        = bundle_q.imm;
   assign bus.ra_o         = bundle_q.ra;
   assign bus.rb_o         = bundle_q.rb;
   assign bus.rw_o         = bundle_q.rw;
   assign bus.rw_src_o     = bundle_q.rw_src;
   assign bus.mem_we_o     = bundle_q.mem_we;
   assign bus.pcwr_en_o    = bundle_q.pcwr;
   assign bus.br_type_o    = bundle_q.br_type;
   assign bus.target_o     = bundle_q.target;
   assign bus.pc_o         = bundle_q.pc;
   assign bus.illegal_o    = bundle_q.illegal;
   assign bus.bubble_cnt_o = bubble_cnt_q;
endmodule

// File: tb/tb_id_stage_hs.sv
// Scoreboard bench for id_stage_hs: issued instructions push hand-decoded bundles,
// a negedge monitor pops and compares each bundle EX accepts.
module tb_id_stage_hs;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   id_stage_hs_if #(.XLEN(32), .CNT_W(16)) bus ();

   id_stage_hs #(.XLEN(32), .CNT_W(16), .LINK_REG(31), .EN_HAZARD(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  ra, rb, rw;
      logic [1:0]  src;
      logic [31:0] imm, tgt, pc;
      logic        we, pcwr;
      logic [1:0]  br;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
   endtask

   // An X in the expected value marks a field the decode leaves unspecified.
   task automatic chk_opt(input string nm, input logic [31:0] act, input logic [31:0] req);
      if (!$isunknown(req)) chk(nm, {32'd0, act}, {32'd0, req});
   endtask

   function automatic exp_t mk(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] rw, input logic [1:0] src,
                               input logic [31:0] imm, input logic [31:0] tgt,
                               input logic [31:0] pc, input logic we, input logic pcwr,
                               input logic [1:0] br, input logic ill);
      exp_t e;
      e.op = op; e.ra = ra; e.rb = rb; e.rw = rw; e.src = src; e.imm = imm; e.tgt = tgt;
      e.pc = pc; e.we = we; e.pcwr = pcwr; e.br = br; e.ill = ill;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_bundle", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk_opt("op", 32'(bus.op_o), 32'(mon_e.op));
            chk_opt("ra", 32'(bus.ra_o), 32'(mon_e.ra));
            chk_opt("rb", 32'(bus.rb_o), 32'(mon_e.rb));
            chk_opt("rw", 32'(bus.rw_o), 32'(mon_e.rw));
            chk_opt("rw_src", 32'(bus.rw_src_o), 32'(mon_e.src));
            chk_opt("imm", bus.imm_o, mon_e.imm);
            chk_opt("target", bus.target_o, mon_e.tgt);
            chk_opt("pc", bus.pc_o, mon_e.pc);
            chk_opt("mem_we", 32'(bus.mem_we_o), 32'(mon_e.we));
            chk_opt("pcwr_en", 32'(bus.pcwr_en_o), 32'(mon_e.pcwr));
            chk_opt("br_type", 32'(bus.br_type_o), 32'(mon_e.br));
            chk_opt("illegal", 32'(bus.illegal_o), 32'(mon_e.ill));
         end
      end
   end

   task automatic issue(input logic [31:0] ir, input logic [31:0] pc, input exp_t e);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.ir_i     = ir;
      bus.pc_i     = pc;
      #1;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) begin
         chk("issue_timeout", 64'd0, 64'd1);
      end else begin
         exp_q.push_back(e);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.ir_i      = '0;
      bus.pc_i      = '0;
      bus.flush_i   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_op", 64'(bus.op_o), 64'h3F);
      chk("rst_rw_src", 64'(bus.rw_src_o), 64'd0);
      chk("rst_imm", 64'(bus.imm_o), 64'd0);
      chk("rst_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LW r2,4(r1) followed by a dependent ADD r3,r2,r3
      issue(32'h8C22_0004, 32'h100,
            mk(6'h23, 5'd1, 'x, 5'd2, 2'b10, 32'h4, 'x, 32'h100, 1'b0, 1'b0, 2'b00, 1'b0));
      bus.in_valid = 1'b1;
      bus.ir_i     = 32'h0043_1820;
      bus.pc_i     = 32'h104;
      #1;
      chk("hazard_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      chk("bubble_out_valid", 64'(bus.out_valid), 64'd0);
      chk("bubble_cnt", 64'(bus.bubble_cnt_o), 64'd1);
      chk("post_bubble_in_ready", 64'(bus.in_ready), 64'd1);
      exp_q.push_back(mk(6'h00, 5'd2, 5'd3, 5'd3, 2'b01, 'x, 'x, 32'h104,
                         1'b0, 1'b0, 2'b00, 1'b0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("add_out_valid", 64'(bus.out_valid), 64'd1);

      issue(32'h1422_FFFF, 32'h200,
            mk(6'h05, 5'd1, 5'd2, 5'd0, 2'b00, 32'hFFFF_FFFF, 32'h200, 32'h200,
               1'b0, 1'b1, 2'b10, 1'b0));
      issue(32'h0C00_0040, 32'h300,
            mk(6'h03, 5'd0, 5'd0, 5'd31, 2'b11, 'x, 32'h100, 32'h300, 1'b0, 1'b1, 2'b11, 1'b0));
      issue(32'h3422_F000, 32'h500,
            mk(6'h0D, 5'd1, 5'd0, 5'd2, 2'b01, 32'h0000_F000, 'x, 32'h500,
               1'b0, 1'b0, 2'b00, 1'b0));
      issue(32'h2022_F000, 32'h504,
            mk(6'h08, 5'd1, 5'd0, 5'd2, 2'b01, 32'hFFFF_F000, 'x, 32'h504,
               1'b0, 1'b0, 2'b00, 1'b0));
      issue(32'h0043_0020, 32'h508,
            mk(6'h00, 5'd2, 5'd3, 5'd0, 2'b00, 'x, 'x, 32'h508, 1'b0, 1'b0, 2'b00, 1'b0));
      issue(32'hFC00_0000, 32'h50C,
            mk(6'h3F, 5'd0, 5'd0, 5'd0, 2'b00, 'x, 'x, 32'h50C, 1'b0, 1'b0, 'x, 1'b1));
      issue(32'h3C05_1234, 32'h510,
            mk(6'h0F, 5'd0, 5'd0, 5'd5, 2'b01, 32'h1234_0000, 'x, 32'h510,
               1'b0, 1'b0, 2'b00, 1'b0));
      @(posedge clk); #1;
      chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
      chk("idle_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd1);

      // SW held by EX back-pressure, then flushed while still held
      bus.out_ready = 1'b0;
      issue(32'hAC22_0008, 32'h600,
            mk(6'h2B, 5'd1, 5'd2, 5'd0, 2'b00, 32'h8, 'x, 32'h600, 1'b1, 1'b0, 2'b00, 1'b0));
      bus.in_valid = 1'b1;
      bus.ir_i     = 32'h2000_0001;
      bus.pc_i     = 32'h604;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
         chk("hold_op", 64'(bus.op_o), 64'h2B);
         chk("hold_imm", 64'(bus.imm_o), 64'h8);
         chk("hold_mem_we", 64'(bus.mem_we_o), 64'd1);
         chk("hold_pc", 64'(bus.pc_o), 64'h600);
         chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
         @(posedge clk);
      end
      #1;
      bus.flush_i = 1'b1;
      #1;
      chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      bus.flush_i   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_after_in_ready", 64'(bus.in_ready), 64'd1);
      chk("flush_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd1);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a pending load-use bubble
      issue(32'h8C22_0004, 32'h700,
            mk(6'h23, 5'd1, 'x, 5'd2, 2'b10, 32'h4, 'x, 32'h700, 1'b0, 1'b0, 2'b00, 1'b0));
      bus.in_valid = 1'b1;
      bus.ir_i     = 32'h0043_1820;
      bus.pc_i     = 32'h704;
      #1;
      chk("rst_hazard_in_ready", 64'(bus.in_ready), 64'd0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_op", 64'(bus.op_o), 64'h3F);
      chk("midrst_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd0);
      chk("midrst_rw_src", 64'(bus.rw_src_o), 64'd0);
      exp_q.delete();
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
